// File: rtl/rr_mux4to1.sv
// rr_mux4to1: 4-to-1 round-robin stream collector.
// Four valid/ready producer channels are merged onto one registered output
// word. Each word is tagged with its 2-bit source index on sel, so (dout, sel)
// can feed the matching 1-to-4 demux directly.
module rr_mux4to1 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       en,
  input  logic             v0,
  input  logic             v1,
  input  logic             v2,
  input  logic             v3,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  output logic             rdy0,
  output logic             rdy1,
  output logic             rdy2,
  output logic             rdy3,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       sel,
  output logic             dout_valid,
  input  logic             dout_ready
);

  // Output register and arbitration pointer
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [1:0]       sel_q, sel_d;
  logic             valid_q, valid_d;
  logic [1:0]       last_q, last_d;

  // Combinational arbitration signals
  logic [3:0]       req_s;
  logic             load_s;
  logic [2:0]       pick_s;
  logic             grant_s;
  logic [1:0]       win_s;
  logic [3:0]       rdy_s;
  logic [WIDTH-1:0] win_data_s;

  // Round-robin pick: returns {found, index}. Offsets are scanned from the
  // farthest (+4, i.e. the last winner itself) to the nearest (+1) so that the
  // nearest requester after the last winner overwrites earlier matches.
  function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) begin
        res = {1'b1, idx};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign req_s   = en & {v3, v2, v1, v0};
  assign load_s  = ~valid_q | dout_ready;
  assign pick_s  = rr_pick(req_s, last_q);
  assign win_s   = pick_s[1:0];
  // No grant while in reset, so no producer sees its word consumed.
  assign grant_s = pick_s[2] & load_s & ~rst;

  // Select the winning channel's data word
  always_comb begin
    win_data_s = {WIDTH{1'b0}};
    case (win_s)
      2'd0:    win_data_s = d0;
      2'd1:    win_data_s = d1;
      2'd2:    win_data_s = d2;
      2'd3:    win_data_s = d3;
      default: win_data_s = {WIDTH{1'b0}};
    endcase
  end

  // One-hot ready back to the winning producer only
  always_comb begin
    rdy_s = 4'b0000;
    if (grant_s) begin
      rdy_s[win_s] = 1'b1;
    end else begin
      rdy_s = 4'b0000;
    end
  end

  assign rdy0 = rdy_s[0];
  assign rdy1 = rdy_s[1];
  assign rdy2 = rdy_s[2];
  assign rdy3 = rdy_s[3];

  // Next state: load on grant, drain on consume, otherwise hold
  always_comb begin
    dout_d  = dout_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    last_d  = last_q;
    if (grant_s) begin
      dout_d  = win_data_s;
      sel_d   = win_s;
      valid_d = 1'b1;
      last_d  = win_s;
    end else if (valid_q & dout_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State register; pointer resets to 3 so channel 0 has first priority
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= {WIDTH{1'b0}};
      sel_q   <= 2'b00;
      valid_q <= 1'b0;
      last_q  <= 2'd3;
    end else begin
      dout_q  <= dout_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign dout       = dout_q;
  assign sel        = sel_q;
  assign dout_valid = valid_q;

endmodule

// File: tb/tb_rr_mux4to1.sv
// Directed self-checking bench for rr_mux4to1 with hand-computed expectations.
module tb_rr_mux4to1;

  logic       clk;
  logic       rst;
  logic [3:0] en;
  logic       v0, v1, v2, v3;
  logic [7:0] d0, d1, d2, d3;
  logic       rdy0, rdy1, rdy2, rdy3;
  logic [7:0] dout;
  logic [1:0] sel;
  logic       dout_valid;
  logic       dout_ready;

  int n_tests;
  int n_fail;

  rr_mux4to1 #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .v0         (v0),
    .v1         (v1),
    .v2         (v2),
    .v3         (v3),
    .d0         (d0),
    .d1         (d1),
    .d2         (d2),
    .d3         (d3),
    .rdy0       (rdy0),
    .rdy1       (rdy1),
    .rdy2       (rdy2),
    .rdy3       (rdy3),
    .dout       (dout),
    .sel        (sel),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] rdy_vec();
    return {rdy3, rdy2, rdy1, rdy0};
  endfunction

  // Check the registered output word
  task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [7:0] d);
    check({tag, ".valid"}, 32'(dout_valid), 32'(v));
    check({tag, ".sel"},   32'(sel),        32'(s));
    check({tag, ".dout"},  32'(dout),       32'(d));
  endtask

  // Hold reset for two edges, then release it just after an edge
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    en  = 4'b1111;
    {v3, v2, v1, v0} = 4'b1111;
    d0 = 8'h10; d1 = 8'h11; d2 = 8'h12; d3 = 8'h13;
    dout_ready = 1'b1;

    // 1. Reset state with every channel requesting
    tick();
    check("t1.rdy_in_rst", 32'(rdy_vec()), 32'h0);
    chk_out("t1.rst", 1'b0, 2'd0, 8'h00);
    tick();
    check("t1.rdy_in_rst2", 32'(rdy_vec()), 32'h0);
    rst = 1'b0;
    #1;
    check("t1.first_grant", 32'(rdy_vec()), 32'h1);

    // 3. Rotation across all four channels
    tick(); chk_out("t3.w0", 1'b1, 2'd0, 8'h10);
    check("t3.rdy_w0", 32'(rdy_vec()), 32'h2);
    tick(); chk_out("t3.w1", 1'b1, 2'd1, 8'h11);
    tick(); chk_out("t3.w2", 1'b1, 2'd2, 8'h12);
    tick(); chk_out("t3.w3", 1'b1, 2'd3, 8'h13);
    check("t3.rdy_wrap", 32'(rdy_vec()), 32'h1);
    tick(); chk_out("t3.w4", 1'b1, 2'd0, 8'h10);
    tick(); chk_out("t3.w5", 1'b1, 2'd1, 8'h11);

    // 4. Backpressure holds the word and blocks all inputs
    do_reset();
    tick(); chk_out("t4.first", 1'b1, 2'd0, 8'h10);
    dout_ready = 1'b0;
    #1;
    check("t4.rdy_bp0", 32'(rdy_vec()), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("t4.hold", 1'b1, 2'd0, 8'h10);
      check("t4.rdy_bp", 32'(rdy_vec()), 32'h0);
    end
    dout_ready = 1'b1;
    #1;
    check("t4.rdy_release", 32'(rdy_vec()), 32'h2);
    tick(); chk_out("t4.next", 1'b1, 2'd1, 8'h11);

    // 5. Mask 1010: only channels 1 and 3 alternate
    en = 4'b1010;
    do_reset();
    check("t5.rdy_first", 32'(rdy_vec()), 32'h2);
    tick(); chk_out("t5.a", 1'b1, 2'd1, 8'h11);
    check("t5.rdy_a", 32'(rdy_vec()), 32'h8);
    tick(); chk_out("t5.b", 1'b1, 2'd3, 8'h13);
    check("t5.rdy_b", 32'(rdy_vec()), 32'h2);
    tick(); chk_out("t5.c", 1'b1, 2'd1, 8'h11);
    tick(); chk_out("t5.d", 1'b1, 2'd3, 8'h13);

    // 2. Single requester (ch2) streams continuously, then drains
    en = 4'b1111;
    {v3, v2, v1, v0} = 4'b0100;
    d2 = 8'hA5;
    do_reset();
    check("t2.rdy_a", 32'(rdy_vec()), 32'h4);
    tick(); chk_out("t2.w0", 1'b1, 2'd2, 8'hA5);
    check("t2.rdy_b", 32'(rdy_vec()), 32'h4);
    tick(); chk_out("t2.w1", 1'b1, 2'd2, 8'hA5);
    v2 = 1'b0;
    #1;
    check("t2.rdy_idle", 32'(rdy_vec()), 32'h0);
    tick(); chk_out("t2.drain", 1'b0, 2'd2, 8'hA5);

    // 6. Reset under backpressure discards the word and restores priority
    {v3, v2, v1, v0} = 4'b1111;
    d2 = 8'h12;
    do_reset();
    tick(); chk_out("t6.w0", 1'b1, 2'd0, 8'h10);
    tick(); chk_out("t6.w1", 1'b1, 2'd1, 8'h11);
    dout_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("t6.rdy_in_rst", 32'(rdy_vec()), 32'h0);
    tick();
    chk_out("t6.rst", 1'b0, 2'd0, 8'h00);
    rst = 1'b0;
    #1;
    check("t6.first_grant", 32'(rdy_vec()), 32'h1);
    tick(); chk_out("t6.after", 1'b1, 2'd0, 8'h10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
